muldiv_sequencer: RTL and testbench

Iterative multi-cycle M-extension unit with its sequencing FSM. Sits in EX beside the ALU. Consumes the decoded muldiv_op from the control unit and the EX operands, and stalls the pipeline while it computes. Drives the result presented on EX_mux6 input 2 once the result is complete.

---
 rtl/muldiv_sequencer.sv | 161 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32 M-extension unit: radix-2 shift-add multiply and restoring divide,
// one step per cycle, with a three-state sequencer that stalls the pipeline while busy.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [3:0]      muldiv_op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    function automatic logic [2*XLEN-1:0] neg_wide(input logic [2*XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          funct3_q;
    logic                neg_q;
    logic [XLEN-1:0]     b_q;
    logic [XLEN-1:0]     result_q;
    logic [2*XLEN-1:0]   acc_q;

    logic [2:0]          f3;
    logic                accept, a_signed, b_signed, a_neg, b_neg, sign_in;
    logic                div_zero, div_ovf, special, last_step;
    logic [XLEN-1:0]     a_mag, b_mag, special_res, quo_rem, calc_res;
    logic [XLEN:0]       mul_sum, div_diff;
    logic [2*XLEN-1:0]   mul_nxt, div_nxt, acc_nxt, prod_fix;
    logic                stall_c, busy_c, valid_c;

    // Operand decode on the accept cycle
    assign f3       = muldiv_op_i[2:0];
    assign accept   = (state_q == IDLE) && muldiv_op_i[3] && !flush_i;
    assign a_signed = (f3 == F_MULH) || (f3 == F_MULHSU) || (f3 == F_DIV) || (f3 == F_REM);
    assign b_signed = (f3 == F_MULH) || (f3 == F_DIV) || (f3 == F_REM);
    assign a_neg    = a_signed && rs1_i[XLEN-1];
    assign b_neg    = b_signed && rs2_i[XLEN-1];
    assign a_mag    = neg_word(rs1_i, a_neg);
    assign b_mag    = neg_word(rs2_i, b_neg);
    assign sign_in  = (f3 == F_REM) ? a_neg : (a_neg ^ b_neg);

    assign div_zero    = f3[2] && (rs2_i == '0);
    assign div_ovf     = ((f3 == F_DIV) || (f3 == F_REM)) && (rs1_i == MIN_NEG) && (rs2_i == ALL_ONES);
    assign special     = div_zero || div_ovf;
    assign special_res = f3[1] ? (div_zero ? rs1_i : '0) : (div_zero ? ALL_ONES : MIN_NEG);

    // Multiply keeps the multiplier in the low half and shifts right;
    // divide keeps {remainder, dividend/quotient} and shifts left.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    assign div_nxt  = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    assign acc_nxt  = funct3_q[2] ? div_nxt : mul_nxt;

    assign prod_fix = neg_wide(acc_nxt, neg_q);
    assign quo_rem  = funct3_q[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
    assign calc_res = funct3_q[2]          ? neg_word(quo_rem, neg_q) :
                      (funct3_q == F_MUL)  ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

    assign last_step = (cnt_q == CNT_W'(XLEN-1));

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        busy_c  = 1'b0;
        valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    stall_c = 1'b1;
                    state_d = special ? DONE : CALC;
                end
            end
            CALC: begin
                busy_c = 1'b1;
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    stall_c = 1'b1;
                    if (last_step) state_d = DONE;
                end
            end
            DONE: begin
                valid_c = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q    <= '0;
            funct3_q <= '0;
            neg_q    <= 1'b0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q    <= '0;
                        funct3_q <= f3;
                        neg_q    <= sign_in;
                        b_q      <= b_mag;
                        acc_q    <= {{XLEN{1'b0}}, a_mag};
                        if (special) result_q <= special_res;
                    end
                end
                CALC: begin
                    if (!flush_i) begin
                        acc_q <= acc_nxt;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_step) result_q <= calc_res;
                    end
                end
                default: ;
            endcase
        end
    end

    // A held op must not stall the pipeline while the unit is in reset
    assign stall_o  = stall_c && reset_i;
    assign busy_o   = busy_c;
    assign valid_o  = valid_c;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops push expected results,
// an independent monitor pops and compares on every valid_o pulse.
module tb_muldiv_sequencer;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [3:0]  muldiv_op_i;
    logic [31:0] rs1_i, rs2_i;
    logic        flush_i;
    logic        stall_o, busy_o, valid_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [31:0] exp_q[$];
    int          vcyc[$];

    muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .muldiv_op_i(muldiv_op_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .flush_i    (flush_i),
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .valid_o    (valid_o),
        .result_o   (result_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation
    always @(negedge clk_i) begin
        if (reset_i && valid_o) begin
            vcyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got result %h expected no valid", result_o);
            end else begin
                check("result", result_o, exp_q.pop_front());
            end
        end
    end

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
        int n;
        n = 0;
        muldiv_op_i = {1'b1, f3};
        rs1_i = a;
        rs2_i = b;
        exp_q.push_back(exp);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk_i);
            if (!stall_o) break;
            n++;
        end
        check({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        check({name, "_valid"}, {31'b0, valid_o}, 32'd1);
        @(posedge clk_i);
        #1;
        muldiv_op_i = '0;
        check({name, "_busy_after"}, {31'b0, busy_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish within 200000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        reset_i     = 1'b0;
        muldiv_op_i = '0;
        rs1_i       = '0;
        rs2_i       = '0;
        flush_i     = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_stall",  {31'b0, stall_o}, 32'd0);
        check("rst_busy",   {31'b0, busy_o},  32'd0);
        check("rst_valid",  {31'b0, valid_o}, 32'd0);
        check("rst_result", result_o,         32'd0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;

        // Flush in IDLE blocks the accept
        muldiv_op_i = 4'b1000;
        rs1_i = 32'd3;
        rs2_i = 32'd3;
        flush_i = 1'b1;
        @(negedge clk_i);
        check("idle_flush_stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        muldiv_op_i = '0;
        @(negedge clk_i);
        check("idle_flush_busy", {31'b0, busy_o}, 32'd0);
        @(posedge clk_i);
        #1;

        run_op("mul_7_m3",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_op("mulh_min_min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        run_op("mulhu_max_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("mulhsu_m1_2",   3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
        run_op("div_m7_2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
        run_op("rem_m7_2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
        run_op("divu_100_7",    3'b101, 32'd100,      32'd7,        32'd14,       33);
        run_op("remu_100_7",    3'b111, 32'd100,      32'd7,        32'd2,        33);

        // Flush a DIVU at CALC counter 10: no result, old result held
        muldiv_op_i = 4'b1101;
        rs1_i = 32'd100;
        rs2_i = 32'd7;
        @(negedge clk_i);
        repeat (11) @(negedge clk_i);
        flush_i = 1'b1;
        muldiv_op_i = '0;
        #1;
        check("flush_stall_same_cycle", {31'b0, stall_o}, 32'd0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        check("flush_busy_next", {31'b0, busy_o}, 32'd0);
        repeat (3) @(negedge clk_i);
        check("flush_result_held", result_o, 32'd2);
        @(posedge clk_i);
        #1;
        run_op("mul_3_4_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 33);

        run_op("divu_5_0",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("rem_5_0",      3'b110, 32'd5,        32'd0,        32'd5,        1);
        run_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

        // Reset at CALC counter 20 with the op still presented
        muldiv_op_i = 4'b1000;
        rs1_i = 32'd3;
        rs2_i = 32'd5;
        @(negedge clk_i);
        repeat (21) @(negedge clk_i);
        check("pre_reset_busy", {31'b0, busy_o}, 32'd1);
        reset_i = 1'b0;
        #1;
        check("midop_rst_stall",  {31'b0, stall_o}, 32'd0);
        check("midop_rst_busy",   {31'b0, busy_o},  32'd0);
        check("midop_rst_valid",  {31'b0, valid_o}, 32'd0);
        check("midop_rst_result", result_o,         32'd0);
        muldiv_op_i = '0;
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Back-to-back: accept in the IDLE cycle right after DONE
        n0 = vcyc.size();
        run_op("b2b_mul", 3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 33);
        run_op("b2b_div", 3'b100, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 33);
        if (vcyc.size() >= n0 + 2)
            check("b2b_valid_gap", 32'(vcyc[n0+1] - vcyc[n0]), 32'd34);
        else
            check("b2b_valid_count", 32'(vcyc.size() - n0), 32'd2);

        repeat (5) @(negedge clk_i);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
